// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in serial-out shift stage.
// Holds the FSM state encoding and the default word width.
package piso_serializer_pkg;

   // Default parallel word width in bits (legal range 2..32).
   localparam int unsigned DEFAULT_WIDTH = 8;

   // Controller state: a single registered bit.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Bit-position counter for the serializer: counts consumed bits of a word.
// Ports: clk, rst_n (async active-low), i_clr (restart at 0),
//        i_inc (advance one bit), o_tc (count == WIDTH-1).
module serial_bit_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_tc
);

   localparam int unsigned CW = $clog2(WIDTH);

   logic [CW-1:0] r_cnt;
   logic          w_tc;

   assign w_tc = (r_cnt == CW'(WIDTH - 1));
   assign o_tc = w_tc;

   // Saturates at the terminal count; only a clear restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && !w_tc) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shift stage feeding the 2:1 mux datapath.
// Ports: clk, rst_n (async active-low); load_valid/load_data/load_ready
//        word handshake; shift_en downstream consume strobe; ser_out,
//        ser_valid, ser_last serial stream; busy word in flight;
//        done one-cycle pulse after the last bit is consumed.
module piso_serializer
   import piso_serializer_pkg::*;
#(
   parameter int unsigned WIDTH     = DEFAULT_WIDTH,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   input  logic             shift_en,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_last,
   output logic             busy,
   output logic             done
);

   state_t           r_state;
   logic [WIDTH-1:0] r_shreg;
   logic             r_done;

   logic w_shift;
   logic w_tc;
   logic w_last;
   logic w_consume;
   logic w_adv;
   logic w_load;
   logic w_bit;

   assign w_shift   = (r_state == ST_SHIFT);
   // Counter holds its terminal value after a word ends; gate by state.
   assign w_last    = w_shift & w_tc;
   assign w_consume = w_shift & shift_en;
   assign w_adv     = w_consume & ~w_tc;

   // Only combinational output: a word may be accepted in IDLE or on the
   // cycle the final bit is consumed, giving bubble-free back-to-back.
   assign load_ready = rst_n & (~w_shift | (w_last & shift_en));
   assign w_load     = load_valid & load_ready;

   assign w_bit = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];

   assign ser_out   = w_shift & w_bit;
   assign ser_valid = w_shift;
   assign ser_last  = w_last;
   assign busy      = w_shift;
   assign done      = r_done;

   serial_bit_counter #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (w_load),
      .i_inc (w_adv),
      .o_tc  (w_tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_shreg <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_consume & w_last;
         if (w_load) begin
            r_state <= ST_SHIFT;
            r_shreg <= load_data;
         end else if (w_consume && w_last) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
         end else if (w_adv) begin
            // Move the next bit toward the output end, zero-filling.
            if (MSB_FIRST) begin
               r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            end else begin
               r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
            end
         end
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: two serializers (8-bit MSB-first, 4-bit LSB-first)
// checked every cycle against a queue-of-bits reference model.
module tb_piso_serializer;

   localparam int NB = 8192;

   logic clk = 1'b0;
   logic rst_n;

   logic        lv  [2];
   logic        se  [2];
   logic [31:0] ldv [2];

   logic o_rdy  [2];
   logic o_out  [2];
   logic o_vld  [2];
   logic o_last [2];
   logic o_busy [2];
   logic o_done [2];

   int n_cmp = 0;
   int n_err = 0;

   bit exp_bits [2][NB];
   int head  [2];
   int cnt   [2];
   bit dpend [2];

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_d8 (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (lv[0]),
      .load_data  (ldv[0][7:0]),
      .load_ready (o_rdy[0]),
      .shift_en   (se[0]),
      .ser_out    (o_out[0]),
      .ser_valid  (o_vld[0]),
      .ser_last   (o_last[0]),
      .busy       (o_busy[0]),
      .done       (o_done[0])
   );

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_d4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (lv[1]),
      .load_data  (ldv[1][3:0]),
      .load_ready (o_rdy[1]),
      .shift_en   (se[1]),
      .ser_out    (o_out[1]),
      .ser_valid  (o_vld[1]),
      .ser_last   (o_last[1]),
      .busy       (o_busy[1]),
      .done       (o_done[1])
   );

   function automatic int wid(int k);
      return (k == 0) ? 8 : 4;
   endfunction

   task automatic chk(string tag, logic obs, logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         head[k]  = 0;
         cnt[k]   = 0;
         dpend[k] = 1'b0;
      end
   endtask

   // All outputs must be low while reset is asserted.
   task automatic chk_zero(string tag);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s_d%0d_rdy", tag, k), o_rdy[k], 1'b0);
         chk($sformatf("%s_d%0d_out", tag, k), o_out[k], 1'b0);
         chk($sformatf("%s_d%0d_vld", tag, k), o_vld[k], 1'b0);
         chk($sformatf("%s_d%0d_last", tag, k), o_last[k], 1'b0);
         chk($sformatf("%s_d%0d_busy", tag, k), o_busy[k], 1'b0);
         chk($sformatf("%s_d%0d_done", tag, k), o_done[k], 1'b0);
      end
   endtask

   // Called at posedge+1 with new inputs already driven.
   task automatic tick(string tag);
      bit ev, el, er, dn;
      #1;
      for (int k = 0; k < 2; k++) begin
         ev = (cnt[k] > 0);
         el = (cnt[k] == 1);
         er = (cnt[k] == 0) || (cnt[k] == 1 && se[k]);
         chk($sformatf("%s_d%0d_vld", tag, k), o_vld[k], ev);
         chk($sformatf("%s_d%0d_busy", tag, k), o_busy[k], ev);
         chk($sformatf("%s_d%0d_last", tag, k), o_last[k], el);
         chk($sformatf("%s_d%0d_rdy", tag, k), o_rdy[k], er);
         chk($sformatf("%s_d%0d_done", tag, k), o_done[k], dpend[k]);
         if (ev)
            chk($sformatf("%s_d%0d_out", tag, k), o_out[k],
                exp_bits[k][head[k]]);
         dn = (cnt[k] == 1) && se[k];
         if (se[k] && cnt[k] > 0) begin
            head[k] = (head[k] + 1) % NB;
            cnt[k]--;
         end
         if (lv[k] && er) begin
            for (int i = 0; i < wid(k); i++) begin
               exp_bits[k][(head[k] + cnt[k]) % NB] =
                  (k == 0) ? ldv[k][wid(k) - 1 - i] : ldv[k][i];
               cnt[k]++;
            end
         end
         dpend[k] = dn;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(int k, logic v, logic [31:0] d, logic s);
      lv[k]  = v;
      ldv[k] = d;
      se[k]  = s;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 1'b0, 32'h0, 1'b0);
      drive(1, 1'b0, 32'h0, 1'b0);
      model_reset();

      // Reset held three cycles, then released.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk_zero("rst");
      end
      rst_n = 1'b1;
      tick("idle");
      tick("idle");

      // Basic MSB-first 8'hA5, shift_en held high.
      drive(0, 1'b1, 32'hA5, 1'b1);
      tick("a5_ld");
      lv[0] = 1'b0;
      for (int i = 0; i < 10; i++) tick("a5");

      // Stall after the second bit of 8'h81.
      drive(0, 1'b1, 32'h81, 1'b1);
      tick("81_ld");
      lv[0] = 1'b0;
      for (int i = 0; i < 2; i++) tick("81_a");
      se[0] = 1'b0;
      for (int i = 0; i < 3; i++) tick("81_stall");
      se[0] = 1'b1;
      for (int i = 0; i < 8; i++) tick("81_b");

      // Back-to-back 8'hF0 then 8'h0F on the last-bit cycle.
      drive(0, 1'b1, 32'hF0, 1'b1);
      tick("f0_ld");
      lv[0] = 1'b0;
      for (int i = 0; i < 7; i++) tick("f0");
      drive(0, 1'b1, 32'h0F, 1'b1);
      tick("b2b");
      lv[0] = 1'b0;
      for (int i = 0; i < 9; i++) tick("0f");

      // LSB-first 4-bit word 4'b0011.
      drive(1, 1'b1, 32'h3, 1'b1);
      tick("lsb_ld");
      lv[1] = 1'b0;
      for (int i = 0; i < 6; i++) tick("lsb");

      // Reset mid-word after three bits of 8'hFF.
      drive(0, 1'b1, 32'hFF, 1'b1);
      tick("ff_ld");
      lv[0] = 1'b0;
      for (int i = 0; i < 3; i++) tick("ff");
      rst_n = 1'b0;
      #1;
      chk_zero("async");
      model_reset();
      @(posedge clk);
      #1;
      chk_zero("async_hold");
      rst_n = 1'b1;
      tick("post_rst");
      drive(0, 1'b1, 32'h01, 1'b1);
      tick("01_ld");
      lv[0] = 1'b0;
      for (int i = 0; i < 10; i++) tick("01");

      // Randomized traffic on both instances.
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 2; k++) begin
            drive(k, 1'($urandom_range(0, 1)), $urandom,
                  1'($urandom_range(0, 3) != 0));
         end
         tick("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
